// File: rtl/scene_sequencer_if.sv
// ---------------------------------------------------------------------------
// scene_sequencer_if
//   Pixel-path bundle between the VGA timing/renderers and the scene
//   sequencer.
//   Timing in  : DrawX[9:0], DrawY[9:0], blank (1 = active region)
//   Game in    : start_btn, game_over (level inputs)
//   Colour in  : title_red/green/blue[3:0], game_red/green/blue[3:0]
//   Colour out : red/green/blue[3:0] (registered)
//   Status out : scene[1:0], frame_tick
//   modport master : drives timing, game and colour inputs, observes outputs
//   modport slave  : the sequencer side
// ---------------------------------------------------------------------------
interface scene_sequencer_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       start_btn;
   logic       game_over;
   logic [3:0] title_red;
   logic [3:0] title_green;
   logic [3:0] title_blue;
   logic [3:0] game_red;
   logic [3:0] game_green;
   logic [3:0] game_blue;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic [1:0] scene;
   logic       frame_tick;

   modport master (
      output DrawX, DrawY, blank, start_btn, game_over,
      output title_red, title_green, title_blue,
      output game_red, game_green, game_blue,
      input  red, green, blue, scene, frame_tick
   );

   modport slave (
      input  DrawX, DrawY, blank, start_btn, game_over,
      input  title_red, title_green, title_blue,
      input  game_red, game_green, game_blue,
      output red, green, blue, scene, frame_tick
   );
endinterface

// File: rtl/scene_sequencer.sv
// ---------------------------------------------------------------------------
// scene_sequencer
//   Screen controller for the VGA output path. Steps the game through the
//   title, play and game-over scenes, picks which renderer reaches the pins
//   and applies frame-synchronous brightness fades.
//   Ports:
//     vga_clk : pixel clock
//     Reset   : synchronous active-high reset
//     px      : scene_sequencer_if.slave (timing, buttons, renderer colours
//               in; registered colour, scene and frame_tick out)
//   Parameters:
//     FRAMES_PER_STEP  : frames held at each brightness level (>= 1)
//     TITLE_MIN_FRAMES : frames the title is fully shown before start counts
//     V_ACTIVE         : first vblank line, where the frame tick is taken
//   Build option:
//     SCENE_SKIP_FADE_EN : when defined, fades jump straight to full/zero
//                          brightness and every fade state lasts two ticks.
// ---------------------------------------------------------------------------
module scene_sequencer #(
   parameter int FRAMES_PER_STEP  = 2,
   parameter int TITLE_MIN_FRAMES = 60,
   parameter int V_ACTIVE         = 480
) (
   input logic             vga_clk,
   input logic             Reset,
   scene_sequencer_if.slave px
);

   localparam int TCNT_W = $clog2(TITLE_MIN_FRAMES + 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TITLE_MIN_FRAMES);
   localparam logic [4:0] LVL_MAX = 5'd16;
   localparam logic [4:0] LVL_MIN = 5'd0;

   typedef enum logic [2:0] {
      TITLE_IN  = 3'd0,
      TITLE     = 3'd1,
      TITLE_OUT = 3'd2,
      GAME_IN   = 3'd3,
      GAME      = 3'd4,
      OVER_OUT  = 3'd5
   } state_t;

   // Scale a 4-bit channel by lvl/16; the 8-bit product never overflows.
   function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] l);
      logic [7:0] prod;
      prod = {4'd0, c} * {3'd0, l};
      return prod[7:4];
   endfunction

   function automatic logic [1:0] scene_of(input state_t s);
      logic [1:0] sc;
      case (s)
         TITLE_IN, TITLE, TITLE_OUT: sc = 2'd0;
         GAME_IN, GAME:              sc = 2'd1;
         OVER_OUT:                   sc = 2'd2;
         default:                    sc = 2'd0;
      endcase
      return sc;
   endfunction

   state_t              state_r, state_nxt, after_s;
   logic [4:0]          lvl_r, lvl_nxt;
   logic [TCNT_W-1:0]   title_cnt_r, tcnt_nxt;
   logic                start_pend_r, start_pend_nxt;
   logic                over_pend_r, over_pend_nxt;
   logic                frame_tick_r;
   logic [1:0]          scene_r;
   logic [3:0]          red_r, green_r, blue_r;
   logic [3:0]          src_red_s, src_green_s, src_blue_s;
   logic                ramp_s, up_s;
`ifndef SCENE_SKIP_FADE_EN
   localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
   logic [STEP_W-1:0]   step_cnt_r, step_nxt;
   logic [4:0]          lvl_step_s;
`endif

   // Frame tick: one pulse after the first vblank pixel is sampled.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         frame_tick_r <= 1'b0;
      end else begin
         frame_tick_r <= (px.DrawX == 10'd0) && (px.DrawY == 10'(V_ACTIVE));
      end
   end

   // Scene state registers; scene output follows the next state.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         state_r      <= TITLE_IN;
         lvl_r        <= 5'd0;
         title_cnt_r  <= '0;
         start_pend_r <= 1'b0;
         over_pend_r  <= 1'b0;
         scene_r      <= 2'd0;
`ifndef SCENE_SKIP_FADE_EN
         step_cnt_r   <= '0;
`endif
      end else begin
         state_r      <= state_nxt;
         lvl_r        <= lvl_nxt;
         title_cnt_r  <= tcnt_nxt;
         start_pend_r <= start_pend_nxt;
         over_pend_r  <= over_pend_nxt;
         scene_r      <= scene_of(state_nxt);
`ifndef SCENE_SKIP_FADE_EN
         step_cnt_r   <= step_nxt;
`endif
      end
   end

   // Next-state logic: request capture every cycle, transitions on ticks only.
   always_comb begin
      state_nxt      = state_r;
      lvl_nxt        = lvl_r;
      tcnt_nxt       = title_cnt_r;
      start_pend_nxt = start_pend_r;
      over_pend_nxt  = over_pend_r;
      after_s        = state_r;
      ramp_s         = 1'b0;
      up_s           = 1'b0;
`ifndef SCENE_SKIP_FADE_EN
      step_nxt       = step_cnt_r;
      lvl_step_s     = lvl_r;
`endif

      if ((state_r == TITLE) && px.start_btn && (title_cnt_r == TCNT_MAX)) begin
         start_pend_nxt = 1'b1;
      end else begin
         start_pend_nxt = start_pend_r;
      end

      if ((state_r == GAME) && px.game_over) begin
         over_pend_nxt = 1'b1;
      end else begin
         over_pend_nxt = over_pend_r;
      end

      if (frame_tick_r) begin
         case (state_r)
            TITLE_IN: begin
               ramp_s   = 1'b1;
               up_s     = 1'b1;
               after_s  = TITLE;
               tcnt_nxt = '0;
            end
            TITLE: begin
               tcnt_nxt = (title_cnt_r == TCNT_MAX) ? title_cnt_r : title_cnt_r + TCNT_W'(1);
               if (start_pend_r) begin
                  state_nxt      = TITLE_OUT;
                  start_pend_nxt = 1'b0;
               end else begin
                  state_nxt = TITLE;
               end
            end
            TITLE_OUT: begin
               ramp_s  = 1'b1;
               after_s = GAME_IN;
            end
            GAME_IN: begin
               ramp_s  = 1'b1;
               up_s    = 1'b1;
               after_s = GAME;
            end
            GAME: begin
               if (over_pend_r) begin
                  state_nxt     = OVER_OUT;
                  over_pend_nxt = 1'b0;
               end else begin
                  state_nxt = GAME;
               end
            end
            OVER_OUT: begin
               ramp_s  = 1'b1;
               after_s = TITLE_IN;
            end
            default: begin
               state_nxt = TITLE_IN;
            end
         endcase
      end else begin
         state_nxt = state_r;
      end

      if (ramp_s) begin
`ifdef SCENE_SKIP_FADE_EN
         // First tick in a fade jumps the level, the second one leaves.
         if (lvl_r != (up_s ? LVL_MAX : LVL_MIN)) begin
            lvl_nxt = up_s ? LVL_MAX : LVL_MIN;
         end else begin
            state_nxt = after_s;
         end
`else
         lvl_step_s = up_s ? lvl_r + 5'd1 : lvl_r - 5'd1;
         if (step_cnt_r == STEP_LAST) begin
            step_nxt = '0;
            lvl_nxt  = lvl_step_s;
            // Leave on the same tick the end level is reached.
            if (lvl_step_s == (up_s ? LVL_MAX : LVL_MIN)) begin
               state_nxt = after_s;
            end else begin
               state_nxt = state_r;
            end
         end else begin
            step_nxt = step_cnt_r + STEP_W'(1);
         end
`endif
      end else begin
         lvl_nxt = lvl_nxt;
      end
   end

   // Source select uses the registered scene so the switch is frame aligned.
   always_comb begin
      src_red_s   = (scene_r == 2'd0) ? px.title_red   : px.game_red;
      src_green_s = (scene_r == 2'd0) ? px.title_green : px.game_green;
      src_blue_s  = (scene_r == 2'd0) ? px.title_blue  : px.game_blue;
   end

   // Output colour register: scaled source, forced black outside active video.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         red_r   <= 4'd0;
         green_r <= 4'd0;
         blue_r  <= 4'd0;
      end else if (px.blank) begin
         red_r   <= scale_chan(src_red_s, lvl_r);
         green_r <= scale_chan(src_green_s, lvl_r);
         blue_r  <= scale_chan(src_blue_s, lvl_r);
      end else begin
         red_r   <= 4'd0;
         green_r <= 4'd0;
         blue_r  <= 4'd0;
      end
   end

   assign px.red        = red_r;
   assign px.green      = green_r;
   assign px.blue       = blue_r;
   assign px.scene      = scene_r;
   assign px.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_scene_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scene_sequencer
//   Randomized bench for scene_sequencer on a shrunken 8x8 raster. A
//   frame-level reference model (phase index, ticks spent in the current
//   fade, request flags) predicts every output each cycle. One reset is
//   injected during the title fade-out at brightness 9.
// ---------------------------------------------------------------------------
module tb_scene_sequencer;
   localparam int FPS   = 2;
   localparam int TMIN  = 60;
   localparam int VACT  = 6;
   localparam int H_TOT = 8;
   localparam int V_TOT = 8;
`ifdef SCENE_SKIP_FADE_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif
   localparam int P_TITLE_IN = 0, P_TITLE = 1, P_TITLE_OUT = 2;
   localparam int P_GAME_IN = 3, P_GAME = 4, P_OVER_OUT = 5;

   logic vga_clk = 1'b0;
   logic Reset;

   scene_sequencer_if u_if ();

   scene_sequencer #(
      .FRAMES_PER_STEP  (FPS),
      .TITLE_MIN_FRAMES (TMIN),
      .V_ACTIVE         (VACT)
   ) u_dut (
      .vga_clk (vga_clk),
      .Reset   (Reset),
      .px      (u_if)
   );

   always #5 vga_clk = ~vga_clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model state
   int m_phase, m_lvl, m_fade_ticks, m_title_frames, m_scene;
   int m_r, m_g, m_b;
   bit m_start_req, m_over_req, m_tick;

   task automatic model_reset();
      m_phase = P_TITLE_IN; m_lvl = 0; m_fade_ticks = 0; m_title_frames = 0;
      m_scene = 0; m_r = 0; m_g = 0; m_b = 0;
      m_start_req = 1'b0; m_over_req = 1'b0; m_tick = 1'b0;
   endtask

   // One frame tick inside a fade phase.
   task automatic model_fade();
      bit up, done;
      up = (m_phase == P_TITLE_IN) || (m_phase == P_GAME_IN);
      m_fade_ticks++;
      if (!SKIP) begin
         m_lvl = up ? m_fade_ticks / FPS : 16 - m_fade_ticks / FPS;
         done  = (m_fade_ticks == 16 * FPS);
      end else begin
         if (m_fade_ticks == 1) m_lvl = up ? 16 : 0;
         done = (m_fade_ticks == 2);
      end
      if (done) begin
         m_fade_ticks = 0;
         m_phase = (m_phase + 1) % 6;
         if (m_phase == P_TITLE) m_title_frames = 0;
      end
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      int sr, sg, sb;
      bit start_set, over_set, new_tick;
      if (Reset) begin
         model_reset();
         return;
      end
      new_tick = (u_if.DrawX == 10'd0) && (u_if.DrawY == 10'(VACT));
      sr = (m_scene == 0) ? int'(u_if.title_red)   : int'(u_if.game_red);
      sg = (m_scene == 0) ? int'(u_if.title_green) : int'(u_if.game_green);
      sb = (m_scene == 0) ? int'(u_if.title_blue)  : int'(u_if.game_blue);
      m_r = u_if.blank ? (sr * m_lvl) / 16 : 0;
      m_g = u_if.blank ? (sg * m_lvl) / 16 : 0;
      m_b = u_if.blank ? (sb * m_lvl) / 16 : 0;
      start_set = (m_phase == P_TITLE) && u_if.start_btn && (m_title_frames == TMIN);
      over_set  = (m_phase == P_GAME) && u_if.game_over;
      if (m_tick) begin
         if (m_phase == P_TITLE) begin
            if (m_title_frames < TMIN) m_title_frames++;
            if (m_start_req) begin
               m_phase = P_TITLE_OUT; m_start_req = 1'b0; start_set = 1'b0;
            end
         end else if (m_phase == P_GAME) begin
            if (m_over_req) begin
               m_phase = P_OVER_OUT; m_over_req = 1'b0; over_set = 1'b0;
            end
         end else begin
            model_fade();
         end
      end
      if (start_set) m_start_req = 1'b1;
      if (over_set)  m_over_req  = 1'b1;
      m_scene = (m_phase <= P_TITLE_OUT) ? 0 : (m_phase <= P_GAME) ? 1 : 2;
      m_tick  = new_tick;
   endtask

   function automatic logic [3:0] rnd_colour();
      logic [3:0] c;
      c = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(15));
      return c;
   endfunction

   initial begin
      int cyc = 0, hx = 0, vy = 0, laps = 0, prev_phase;
      bit mid_rst_done = 1'b0, mid_rst_now;
      model_reset();
      Reset = 1'b1;
      u_if.DrawX = 10'd0; u_if.DrawY = 10'd0; u_if.blank = 1'b0;
      u_if.start_btn = 1'b0; u_if.game_over = 1'b0;
      u_if.title_red = 4'd0; u_if.title_green = 4'd0; u_if.title_blue = 4'd0;
      u_if.game_red = 4'd0; u_if.game_green = 4'd0; u_if.game_blue = 4'd0;

      while (cyc < 60000 && !(mid_rst_done && laps >= 1)) begin
         mid_rst_now = 1'b0;
         if (!mid_rst_done && m_phase == P_TITLE_OUT && (SKIP || m_lvl == 9)) begin
            mid_rst_now  = 1'b1;
            mid_rst_done = 1'b1;
         end
         Reset            = (cyc < 3) || mid_rst_now;
         u_if.DrawX       = 10'(hx);
         u_if.DrawY       = 10'(vy);
         u_if.blank       = ($urandom_range(3) != 0);
         u_if.start_btn   = ($urandom_range(149) == 0);
         u_if.game_over   = ($urandom_range(199) == 0);
         u_if.title_red   = rnd_colour();
         u_if.title_green = rnd_colour();
         u_if.title_blue  = rnd_colour();
         u_if.game_red    = rnd_colour();
         u_if.game_green  = rnd_colour();
         u_if.game_blue   = rnd_colour();

         @(posedge vga_clk);
         prev_phase = m_phase;
         model_step();
         if (mid_rst_done && !mid_rst_now && prev_phase == P_OVER_OUT && m_phase == P_TITLE_IN)
            laps++;

         @(negedge vga_clk);
         check_val("red",        32'(u_if.red),        32'(m_r));
         check_val("green",      32'(u_if.green),      32'(m_g));
         check_val("blue",       32'(u_if.blue),       32'(m_b));
         check_val("scene",      32'(u_if.scene),      32'(m_scene));
         check_val("frame_tick", 32'(u_if.frame_tick), 32'(m_tick));
         if (mid_rst_now) begin
            check_val("midreset_scene", 32'(u_if.scene), 32'd0);
            check_val("midreset_red",   32'(u_if.red),   32'd0);
         end

         hx++;
         if (hx == H_TOT) begin
            hx = 0;
            vy = (vy + 1) % V_TOT;
         end
         cyc++;
      end

      check_val("progress_timeout", 32'(mid_rst_done && laps >= 1), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Top-level screen controller for the VGA output path.
- Sequences the game through the title, play and game-over scenes, and selects which renderer's RGB stream reaches the pins.
- Applies frame-synchronous fade-in/fade-out brightness ramps.
- Sits between the title-screen and game renderers and the VGA output registers, in the vga_clk domain.

Parameters:
- FRAMES_PER_STEP, 2, frames held at each brightness level during a fade (>=1).
- TITLE_MIN_FRAMES, 60, frames the title must be fully shown before start_btn is accepted.
- V_ACTIVE, 480, DrawY value of the first vblank line; frame tick position.

Ports:
- vga_clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column from the VGA controller.
- DrawY  in  10  current pixel row from the VGA controller.
- blank  in  1  1 = active display region, 0 = blanking.
- start_btn  in  1  level; request to leave the title scene.
- game_over  in  1  level; game logic signals loss.
- title_red/title_green/title_blue  in  4 each  title renderer colour.
- game_red/game_green/game_blue  in  4 each  game renderer colour.
- red/green/blue  out  4 each  final registered pixel colour.
- scene  out  2  0 = title, 1 = game, 2 = game-over fade; registered.
- frame_tick  out  1  one-cycle pulse per frame.

Behaviour:
- Clocking and reset:
  - All state updates on posedge vga_clk.
  - While Reset=1: state=TITLE_IN, lvl=0, step_cnt=0, title_cnt=0, start_pend=0, over_pend=0, red/green/blue=0, scene=0, frame_tick=0.
  - Reset mid-fade or mid-scene aborts immediately to these values.
- frame_tick:
  - Registered; asserted the cycle after DrawX==0 && DrawY==V_ACTIVE is sampled, for exactly one cycle per frame.
  - All state and lvl changes occur only in the cycle in which frame_tick is asserted. Scene and brightness never change mid-visible-frame.
- Brightness:
  - lvl is 5 bits, range 0..16.
  - During a fade, step_cnt counts frame ticks. When step_cnt reaches FRAMES_PER_STEP-1 it clears and lvl steps by one; otherwise it increments.
- States (per frame tick):
  - TITLE_IN: lvl++ per step; at lvl==16 -> TITLE, title_cnt=0.
  - TITLE: title_cnt increments, saturating at TITLE_MIN_FRAMES. start_pend is set in any cycle where start_btn=1 and title_cnt==TITLE_MIN_FRAMES. Next tick with start_pend=1 -> TITLE_OUT, start_pend cleared.
  - TITLE_OUT: lvl-- per step; at lvl==0 -> GAME_IN.
  - GAME_IN: lvl++ per step; at lvl==16 -> GAME.
  - GAME: over_pend is set by game_over=1 in any cycle. Next tick with over_pend=1 -> OVER_OUT, over_pend cleared.
  - OVER_OUT: lvl-- per step; at lvl==0 -> TITLE_IN.
- Ignored inputs:
  - start_btn is ignored in every state except TITLE.
  - game_over is ignored in every state except GAME.
  - Inputs are level-sampled every cycle, so pulses shorter than a frame are captured.
- scene output: TITLE_IN/TITLE/TITLE_OUT -> 0; GAME_IN/GAME -> 1; OVER_OUT -> 2. Registered alongside state.
- Colour path:
  - src = title_* when scene==0, game_* otherwise.
  - Per channel: out = (src * lvl) >> 4, using an 8-bit intermediate and truncating to 4 bits. lvl=16 passes the value unchanged; lvl=0 gives 0.
  - Outputs are registered with 1-cycle latency from the input colour.
  - The registered output is forced to 0 when blank=0 in the sampled cycle.

Optional Feature:
- Macro: SCENE_SKIP_FADE_EN.
- Defined:
  - Fades are bypassed.
  - Each *_IN state sets lvl=16 and each *_OUT state sets lvl=0, at the first frame tick spent in that state.
  - The state advances on the following tick, so every fade state lasts exactly 2 frame ticks and FRAMES_PER_STEP is unused.
- Undefined: normal ramp as described in Behaviour.

Test Plan:
- Reset, then FRAMES_PER_STEP=2 -> lvl rises 0->16 over 32 frame ticks and the state enters TITLE on the 32nd tick. With title_red=15 at lvl=8, red=7 one cycle later.
- start_btn=1 at title_cnt=10 with TITLE_MIN_FRAMES=60 -> stays in TITLE. start_btn pulsed for 1 cycle after title_cnt==60 -> TITLE_OUT on the next tick, then scene=1 once lvl reaches 0.
- In GAME, a 1-cycle game_over pulse mid-frame -> scene stays 1 until the next frame_tick, then enters OVER_OUT (scene=2) and returns to TITLE_IN with scene=0 after the ramp.
- blank=0 with game_red=15 at lvl=16 -> red=0. blank=1 -> red=15 exactly 1 cycle later.
- Assert Reset during TITLE_OUT at lvl=9 -> next cycle: state TITLE_IN, lvl=0, outputs 0, start_pend=0.
- With SCENE_SKIP_FADE_EN defined: TITLE_IN lasts 2 frame ticks, lvl jumps 0->16 with no intermediate values, and the start-to-game transition completes in 4 ticks.
